// File: rtl/qsfp_i2c_pkg.sv
// Shared definitions for the QSFP lower-page I2C target: FSM encoding,
// acknowledge levels and bit-counter width.
package qsfp_i2c_pkg;

    localparam int BIT_CNT_W = 4;

    // Open-drain levels as seen on SDA during the acknowledge clock
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] ST_IDLE_ENC      = 4'd0;
    localparam logic [3:0] ST_ADDR_ENC      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK_ENC  = 4'd2;
    localparam logic [3:0] ST_PTR_ENC       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK_ENC   = 4'd4;
    localparam logic [3:0] ST_WDATA_ENC     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK_ENC = 4'd6;
    localparam logic [3:0] ST_RDATA_ENC     = 4'd7;
    localparam logic [3:0] ST_RD_MACK_ENC   = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP_ENC = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_ADDR      = ST_ADDR_ENC,
        ST_ADDR_ACK  = ST_ADDR_ACK_ENC,
        ST_PTR       = ST_PTR_ENC,
        ST_PTR_ACK   = ST_PTR_ACK_ENC,
        ST_WDATA     = ST_WDATA_ENC,
        ST_WDATA_ACK = ST_WDATA_ACK_ENC,
        ST_RDATA     = ST_RDATA_ENC,
        ST_RD_MACK   = ST_RD_MACK_ENC,
        ST_WAIT_STOP = ST_WAIT_STOP_ENC
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line; emits
// one-cycle rise/fall pulses aligned with the filtered value changing.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic raw,
    output logic filt,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            // Any cycle agreeing with the filtered value restarts the count
            if (sync[1] != filt) begin
                if (cnt == CW'(FILTER_LEN - 1)) begin
                    filt <= sync[1];
                    rise <= sync[1];
                    fall <= ~sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/qsfp_i2c_target.sv
// I2C target emulating a QSFP lower management page: device address match,
// byte pointer with auto-increment, register file with a local write port.
module qsfp_i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         MEM_AW     = 7,
    parameter int         FILTER_LEN = 4,
    parameter int         SDA_HOLD   = 30
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_t,
    input  logic              loc_wr_en,
    input  logic [MEM_AW-1:0] loc_wr_addr,
    input  logic [7:0]        loc_wr_data,
    output logic              wr_strobe,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    import qsfp_i2c_pkg::*;

    localparam int HW = $clog2(SDA_HOLD + 1);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .aclk(aclk), .aresetn(aresetn), .raw(scl_i),
        .filt(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .aclk(aclk), .aresetn(aresetn), .raw(sda_i),
        .filt(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    i2c_state_e           state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, cnt_nxt;
    logic [MEM_AW-1:0]    ptr;
    logic [6:0]           rx_sh;
    logic [7:0]           rx_byte, tx_sh, rd_byte;
    logic                 rw, mack;
    logic                 pend, sda_pend;
    logic [HW-1:0]        hold_cnt;
    logic [7:0]           mem [2**MEM_AW];

    assign rx_byte = {rx_sh, sda_f};
    assign rd_byte = mem[ptr];

    logic shift_en, set_busy, clr_busy, rw_cap, mack_cap;
    logic ptr_load, ptr_inc, mem_we, tx_load, rel_now, sched, sched_val;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Acknowledge states use bit_cnt as a phase: 0 = before the 8th SCL fall, 1 = after
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shift_en  = 1'b0;
        set_busy  = 1'b0;
        clr_busy  = 1'b0;
        rw_cap    = 1'b0;
        mack_cap  = 1'b0;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        mem_we    = 1'b0;
        tx_load   = 1'b0;
        rel_now   = 1'b0;
        sched     = 1'b0;
        sched_val = NACK;
        if (stop_det) begin
            state_nxt = ST_IDLE;
            clr_busy  = 1'b1;
            rel_now   = 1'b1;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = '0;
            rel_now   = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_nxt  = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(7)) begin
                            cnt_nxt = '0;
                            if (state == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_nxt = ST_ADDR_ACK;
                                    set_busy  = 1'b1;
                                    rw_cap    = 1'b1;
                                end else begin
                                    state_nxt = ST_WAIT_STOP;
                                end
                            end else if (state == ST_PTR) begin
                                ptr_load  = 1'b1;
                                state_nxt = ST_PTR_ACK;
                            end else begin
                                mem_we    = 1'b1;
                                ptr_inc   = 1'b1;
                                state_nxt = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sched = 1'b1;
                        if (bit_cnt == '0) begin
                            cnt_nxt   = BIT_CNT_W'(1);
                            sched_val = ACK;
                        end else begin
                            cnt_nxt = '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                tx_load   = 1'b1;
                                sched_val = rd_byte[7];
                                state_nxt = ST_RDATA;
                            end else if (state == ST_ADDR_ACK) begin
                                state_nxt = ST_PTR;
                            end else begin
                                state_nxt = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_nxt = bit_cnt + 1'b1;
                    end else if (scl_fall) begin
                        sched = 1'b1;
                        if (bit_cnt == BIT_CNT_W'(8)) begin
                            ptr_inc   = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_RD_MACK;
                        end else begin
                            sched_val = tx_sh[3'(7 - bit_cnt)];
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_rise) begin
                        mack_cap = 1'b1;
                    end else if (scl_fall) begin
                        sched = 1'b1;
                        if (mack == ACK) begin
                            tx_load   = 1'b1;
                            sched_val = rd_byte[7];
                            state_nxt = ST_RDATA;
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sda_t     <= 1'b1;
            pend      <= 1'b0;
            sda_pend  <= 1'b1;
            hold_cnt  <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            rw        <= 1'b0;
            mack      <= NACK;
        end else begin
            wr_strobe <= mem_we;
            if (mem_we) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
            if (set_busy) busy <= 1'b1;
            else if (clr_busy) busy <= 1'b0;
            if (ptr_load) ptr <= rx_byte[MEM_AW-1:0];
            else if (ptr_inc) ptr <= ptr + 1'b1;
            if (shift_en) rx_sh <= rx_byte[6:0];
            if (tx_load) tx_sh <= rd_byte;
            if (rw_cap) rw <= rx_byte[0];
            if (mack_cap) mack <= sda_f;
            // SDA changes only after the hold delay following an SCL fall
            if (rel_now) begin
                sda_t <= 1'b1;
                pend  <= 1'b0;
            end else if (sched) begin
                pend     <= 1'b1;
                sda_pend <= sched_val;
                hold_cnt <= '0;
            end else if (pend) begin
                if (hold_cnt == HW'(SDA_HOLD - 1)) begin
                    sda_t <= sda_pend;
                    pend  <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    // Register file: the I2C write is placed last so it wins a same-address collision
    always_ff @(posedge aclk) begin
        if (loc_wr_en) mem[loc_wr_addr] <= loc_wr_data;
        if (mem_we) mem[ptr] <= rx_byte;
    end

endmodule
